// File: rtl/spi_rx_pkg.sv
// Shared types and defaults for the SPI packet receiver.
//   DEFAULT_HEADER : value byte 0 must carry unless the top overrides HEADER
//   err_code_t     : rejection cause reported on err_code
//   state_t        : receiver FSM states
package spi_rx_pkg;

  localparam logic [7:0] DEFAULT_HEADER = 8'hAA;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_LEN  = 2'd1,
    ERR_HDR  = 2'd2,
    ERR_CSUM = 2'd3
  } err_code_t;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    CHECK
  } state_t;

endpackage

// File: rtl/spi_rx_sync.sv
// Three-flop synchroniser with registered edge pulses.
//   RESET_LEVEL : idle level every flop resets to
//   clk, rst_n  : system clock, async active-low reset
//   async_in    : asynchronous pin
//   level       : synchronised level (second flop)
//   rise, fall  : one-cycle pulses, registered, one cycle after level changes
module spi_rx_sync #(
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic q1, q2, q3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1   <= RESET_LEVEL;
      q2   <= RESET_LEVEL;
      q3   <= RESET_LEVEL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      q1   <= async_in;
      q2   <= q1;
      q3   <= q2;
      rise <= q2 & ~q3;
      fall <= ~q2 & q3;
    end
  end

  assign level = q2;

endmodule

// File: rtl/spi_packet_rx.sv
// SPI mode-0 slave receiver for fixed-length sensor packets. All pins are
// oversampled in the clk domain; nothing is clocked by sck.
// Packet: byte 0 header, bytes 1..2*NUM_CH channels (MSB first), byte
// 2*NUM_CH+1 flags, remaining bytes reserved.
// Optional feature macro: SPI_RX_CHECKSUM_EN -- last byte must equal the
// 8-bit sum of all preceding bytes. Without it the last byte is ignored.
// Ports:
//   clk, rst_n      : system clock, async active-low reset
//   cs_n, sck, sdi  : asynchronous SPI pins
//   ch_data         : NUM_CH signed int16 channels, channel k at [16k+15:16k]
//   flags           : flags byte of the last good packet
//   data_valid      : sticky, set by the first good packet
//   frame_valid     : one-cycle pulse, outputs updated by a good packet
//   frame_err       : one-cycle pulse, packet rejected
//   err_code        : cause of last rejection (0 none, 1 len, 2 hdr, 3 csum)
//   frame_cnt       : good packets, wraps
//   err_cnt         : rejected packets, saturates
// PKT_BYTES must be at least 2*NUM_CH+3.
module spi_packet_rx
  import spi_rx_pkg::*;
#(
  parameter int unsigned PKT_BYTES = 16,
  parameter int unsigned NUM_CH    = 6,
  parameter logic [7:0]  HEADER    = DEFAULT_HEADER
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cs_n,
  input  logic                   sck,
  input  logic                   sdi,
  output logic [NUM_CH*16-1:0]   ch_data,
  output logic [7:0]             flags,
  output logic                   data_valid,
  output logic                   frame_valid,
  output logic                   frame_err,
  output logic [1:0]             err_code,
  output logic [15:0]            frame_cnt,
  output logic [15:0]            err_cnt
);

  localparam int unsigned CNT_W     = $clog2(PKT_BYTES + 1);
  localparam int unsigned FLAGS_IDX = 2 * NUM_CH + 1;

  // Pin synchronisation
  logic cs_n_sync, cs_rise, cs_fall;
  logic sck_level, sck_rise, sck_fall;
  logic sdi_q1, sdi_sync;

  spi_rx_sync #(
    .RESET_LEVEL (1'b1)
  ) u_cs_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (cs_n),
    .level    (cs_n_sync),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  spi_rx_sync #(
    .RESET_LEVEL (1'b0)
  ) u_sck_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (sck),
    .level    (sck_level),
    .rise     (sck_rise),
    .fall     (sck_fall)
  );

  logic unused_sck;
  assign unused_sck = sck_level ^ sck_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdi_q1   <= 1'b0;
      sdi_sync <= 1'b0;
    end else begin
      sdi_q1   <= sdi;
      sdi_sync <= sdi_q1;
    end
  end

  // The cs synchroniser resets to "high", so a cs_n held low through reset
  // looks like a fall once reset releases. Only accept falls after cs_n has
  // been seen high with the synchroniser settled, so a packet cut by reset
  // is ignored to its end.
  logic [1:0] settle_cnt;
  logic       armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= 2'd0;
      armed      <= 1'b0;
    end else if (settle_cnt != 2'd3) begin
      settle_cnt <= settle_cnt + 2'd1;
    end else if (cs_n_sync) begin
      armed <= 1'b1;
    end
  end

  // Receive state
  state_t           state;
  logic [2:0]       bit_cnt;
  logic [CNT_W-1:0] byte_cnt;
  logic             overrun;
  logic [6:0]       shift;
  logic [7:0]       pkt_buf [PKT_BYTES];
  logic [7:0]       rx_byte;
`ifdef SPI_RX_CHECKSUM_EN
  logic [7:0]       sum;
`endif

  assign rx_byte = {shift, sdi_sync};

  // A new frame starts from IDLE on a fresh fall, or straight out of CHECK
  // when the next cs_n low already arrived during evaluation.
  logic start_frame;
  assign start_frame = ((state == IDLE) && cs_fall && armed) ||
                       ((state == CHECK) && !cs_n_sync);

  // Packet evaluation
  logic                 len_err, hdr_err, csum_err;
  err_code_t            chk_code;
  logic [NUM_CH*16-1:0] new_ch;

  always_comb begin
    len_err  = (byte_cnt != CNT_W'(PKT_BYTES)) || overrun || (bit_cnt != 3'd0);
    hdr_err  = (pkt_buf[0] != HEADER);
`ifdef SPI_RX_CHECKSUM_EN
    csum_err = (pkt_buf[PKT_BYTES-1] != sum);
`else
    csum_err = 1'b0;
`endif
    if (len_err) begin
      chk_code = ERR_LEN;
    end else if (hdr_err) begin
      chk_code = ERR_HDR;
    end else if (csum_err) begin
      chk_code = ERR_CSUM;
    end else begin
      chk_code = ERR_NONE;
    end
  end

  always_comb begin
    new_ch = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      new_ch[16*k +: 16] = {pkt_buf[1 + 2*k], pkt_buf[2 + 2*k]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      byte_cnt    <= '0;
      overrun     <= 1'b0;
      shift       <= 7'd0;
      for (int i = 0; i < PKT_BYTES; i++) begin
        pkt_buf[i] <= 8'd0;
      end
`ifdef SPI_RX_CHECKSUM_EN
      sum         <= 8'd0;
`endif
      ch_data     <= '0;
      flags       <= 8'd0;
      data_valid  <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= 2'd0;
      frame_cnt   <= 16'd0;
      err_cnt     <= 16'd0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;

      if (start_frame) begin
        bit_cnt  <= 3'd0;
        byte_cnt <= '0;
        overrun  <= 1'b0;
`ifdef SPI_RX_CHECKSUM_EN
        sum      <= 8'd0;
`endif
      end

      case (state)
        IDLE: begin
          if (start_frame) state <= RECV;
        end

        RECV: begin
          if (cs_rise) begin
            state <= CHECK;
          end else if (sck_rise) begin
            shift <= rx_byte[6:0];
            if (bit_cnt == 3'd7) begin
              bit_cnt <= 3'd0;
              if (byte_cnt < CNT_W'(PKT_BYTES)) begin
                for (int i = 0; i < PKT_BYTES; i++) begin
                  if (byte_cnt == CNT_W'(i)) pkt_buf[i] <= rx_byte;
                end
                byte_cnt <= byte_cnt + 1'b1;
`ifdef SPI_RX_CHECKSUM_EN
                // The checksum byte itself is not part of the sum.
                if (byte_cnt < CNT_W'(PKT_BYTES - 1)) sum <= sum + rx_byte;
`endif
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end

        CHECK: begin
          if (chk_code == ERR_NONE) begin
            ch_data     <= new_ch;
            flags       <= pkt_buf[FLAGS_IDX];
            data_valid  <= 1'b1;
            frame_cnt   <= frame_cnt + 16'd1;
            frame_valid <= 1'b1;
          end else begin
            err_code  <= chk_code;
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            frame_err <= 1'b1;
          end
          state <= start_frame ? RECV : IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
